// File: rtl/tick_pkg.sv
// ============================================================================
//  Module      : tick_pkg
//  Description : Shared state encoding and clock constants for tick_prescaler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int unsigned SYS_CLK_HZ  = 50_000_000;
    localparam int unsigned DEFAULT_DIV = SYS_CLK_HZ;
    localparam int unsigned SIM_DIV     = 20;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
//  Module      : tick_prescaler
//  Description : Runtime-loadable clock-enable prescaler producing a one-cycle
//                tick strobe, with glitch-free divisor loading and a tick count.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import tick_pkg::*;
#(
    parameter int W           = 26,
    parameter int DEFAULT_DIV = tick_pkg::DEFAULT_DIV,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_valid,
    input  logic [W-1:0]     div_data,
    output logic             div_ready,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count
);

    localparam logic [W-1:0] c_div_rst = W'(DEFAULT_DIV);
    localparam logic [W-1:0] c_one     = W'(1);

    state_t             r_state;
    logic [W-1:0]       r_cnt;
    logic [W-1:0]       r_div;
    logic [W-1:0]       r_pend;
    logic               r_tick;
    logic [CNT_W-1:0]   r_tick_count;

    logic               w_accept;
    logic [W-1:0]       w_load_val;
    logic               w_wrap;
    logic               w_tick_next;

    assign div_ready  = (r_state != PEND);
    assign w_accept   = div_valid & div_ready;
    assign w_load_val = (div_data == '0) ? c_one : div_data;
    assign w_wrap     = (r_cnt == (r_div - c_one));

    // A wrap seen while leaving RUN/PEND still delivers its tick.
    assign w_tick_next = (r_state == IDLE) ? (en & w_wrap) : w_wrap;

    assign tick       = r_tick;
    assign tick_count = r_tick_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_div        <= c_div_rst;
            r_pend       <= '0;
            r_tick       <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_tick       <= w_tick_next;
            r_tick_count <= r_tick_count + {{(CNT_W-1){1'b0}}, w_tick_next};

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_div <= w_load_val;
                    end
                    if (en) begin
                        r_state <= RUN;
                        r_cnt   <= w_wrap ? '0 : r_cnt + c_one;
                    end else begin
                        r_cnt   <= '0;
                    end
                end

                RUN: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        if (w_accept) begin
                            r_div <= w_load_val;
                        end
                    end else begin
                        r_cnt <= w_wrap ? '0 : r_cnt + c_one;
                        if (w_accept) begin
                            // On the wrap edge the next period has not begun yet.
                            if (w_wrap) begin
                                r_div <= w_load_val;
                            end else begin
                                r_pend  <= w_load_val;
                                r_state <= PEND;
                            end
                        end
                    end
                end

                PEND: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_div   <= r_pend;
                    end else begin
                        r_cnt <= w_wrap ? '0 : r_cnt + c_one;
                        if (w_wrap) begin
                            r_div   <= r_pend;
                            r_state <= RUN;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_prescaler.sv
// ============================================================================
//  Module      : tb_tick_prescaler
//  Description : Self-checking bench for tick_prescaler against a period-level
//                reference model, with directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tick_prescaler;

    localparam int W     = 26;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             div_valid;
    logic [W-1:0]     div_data;
    logic             div_ready;
    logic             tick;
    logic [CNT_W-1:0] tick_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position inside the current period and the divisors.
    bit         m_run;
    bit         m_pvalid;
    int         m_per;
    int         m_pend;
    int         m_el;
    bit         m_tick;
    bit [7:0]   m_cnt;

    tick_prescaler #(
        .W           (W),
        .DEFAULT_DIV (20),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_valid  (div_valid),
        .div_data   (div_data),
        .div_ready  (div_ready),
        .tick       (tick),
        .tick_count (tick_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_pvalid = 1'b0;
        m_per    = 20;
        m_pend   = 0;
        m_el     = 0;
        m_tick   = 1'b0;
        m_cnt    = 8'd0;
    endtask

    task automatic model_edge(input bit e, input bit dv, input int dd);
        int  val;
        int  nxt;
        bit  acc;
        bit  last;
        val  = (dd == 0) ? 1 : dd;
        acc  = dv && !m_pvalid;
        last = (m_el + 1 == m_per);
        if (!m_run) begin
            m_tick = e && last;
            if (acc) m_per = val;
            if (e) begin
                m_run = 1'b1;
                m_el  = last ? 0 : m_el + 1;
            end else begin
                m_el = 0;
            end
        end else begin
            m_tick = last;
            nxt    = m_pvalid ? m_pend : (acc ? val : m_per);
            if (!e) begin
                m_run = 1'b0; m_el = 0; m_per = nxt; m_pvalid = 1'b0;
            end else if (last) begin
                m_el = 0; m_per = nxt; m_pvalid = 1'b0;
            end else begin
                m_el++;
                if (acc) begin
                    m_pend = val; m_pvalid = 1'b1;
                end
            end
        end
        if (m_tick) m_cnt++;
    endtask

    // Drive one cycle of inputs from a falling edge, then check at the next one.
    task automatic step(input bit e, input bit dv, input int dd);
        en        = e;
        div_valid = dv;
        div_data  = dd[W-1:0];
        @(posedge clk);
        model_edge(e, dv, dd);
        @(negedge clk);
        check("tick", tick, m_tick);
        check("tick_count", tick_count, m_cnt);
        check("div_ready", div_ready, !m_pvalid);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1'b1, 1'b0, 0);
            n++;
        end while (tick !== 1'b1 && n < 100);
        if (n >= 100) check("wait_tick_timeout", 0, 1);
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (m_el != target && guard < 100) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        if (guard >= 100) check("run_until_timeout", 0, 1);
    endtask

    initial begin
        int n;
        bit [7:0] c0;

        rst_n = 1'b0; en = 1'b0; div_valid = 1'b0; div_data = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_tick", tick, 0);
        check("rst_count", tick_count, 0);
        check("rst_ready", div_ready, 1);
        rst_n = 1'b1;

        // Default divisor: first tick 20 clocks after enable, then every 20.
        repeat (3) step(1'b0, 1'b0, 0);
        wait_tick(n); check("first_tick", n, 20);
        wait_tick(n); check("period_20", n, 20);
        check("count_after_2", tick_count, 2);

        // Drop enable mid-period; re-enable restarts a full period.
        run_until(10);
        step(1'b0, 1'b0, 0);
        check("drop_no_tick", tick, 0);
        repeat (3) step(1'b0, 1'b0, 0);
        wait_tick(n); check("reenable_first", n, 20);

        // Load 5 mid-period: current period still completes.
        run_until(7);
        step(1'b1, 1'b1, 5);
        check("pend_ready_low", div_ready, 0);
        wait_tick(n); check("rest_of_period", n, 12);
        check("ready_after_wrap", div_ready, 1);
        wait_tick(n); check("period_5", n, 5);

        // Load on the wrap cycle itself applies to the very next period.
        run_until(4);
        check("wrap_ready", div_ready, 1);
        step(1'b1, 1'b1, 3);
        check("wrap_tick", tick, 1);
        check("wrap_stays_run", div_ready, 1);
        wait_tick(n); check("period_3", n, 3);

        // Reset while a divisor is pending discards it.
        step(1'b1, 1'b1, 7);
        check("pend_before_rst", div_ready, 0);
        step(1'b1, 1'b0, 0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_tick", tick, 0);
        check("async_rst_count", tick_count, 0);
        check("async_rst_ready", div_ready, 1);
        en = 1'b0; div_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 0);
        wait_tick(n); check("post_rst_period", n, 20);
        wait_tick(n); check("post_rst_period2", n, 20);

        // Divisor 0 clamps to 1: tick every cycle and the count wraps.
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        c0 = m_cnt;
        repeat (256) step(1'b1, 1'b0, 0);
        check("div1_tick_high", tick, 1);
        check("count_wrap", tick_count, c0);

        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 20);

        // Random traffic on enable, loads and small divisors.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 16) != 0, ($urandom % 6) == 0, int'($urandom % 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tick_prescaler.md
# tick_prescaler

Clock-enable prescaler that produces the one-cycle `tick` strobe consumed directly by `traffic_light`. It divides the 50 MHz system clock by a runtime-loadable divisor, 50,000,000 by default for a 1 Hz tick. A valid/ready port lets a new divisor be loaded glitch-free, so fast simulation and real-time operation share one RTL. It also keeps a wrapping count of issued ticks for debug and bench checking.

## Interface
- `W`, 26: width of counter and divisor.
- `DEFAULT_DIV`, 50_000_000: divisor loaded at reset; benches override to 20.
- `CNT_W`, 8: width of `tick_count`.

- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  run enable; low holds the prescaler idle.
- `div_valid`  in  1  a new divisor is offered on `div_data`.
- `div_data`  in  W  divisor value; 0 is clamped to 1.
- `div_ready`  out  1  the block can accept a divisor this cycle.
- `tick`  out  1  registered strobe to `traffic_light`, high exactly one clock per period.
- `tick_count`  out  CNT_W  number of ticks issued, modulo 2^CNT_W.

## Operation
- State machine:
  - IDLE: `en`=0. Counter held at 0, `tick`=0.
  - RUN: counting, no divisor pending.
  - PEND: counting, new divisor stored in `pend_reg`.
- Transitions:
  - IDLE→RUN on `en`=1.
  - RUN/PEND→IDLE on `en`=0, from any state. The counter clears. A pending divisor is applied at once: `div_reg`<=`pend_reg`.
  - RUN→PEND on an accepted load in a non-wrap cycle.
  - PEND→RUN on wrap. `div_reg`<=`pend_reg`.
- Load transfer occurs when `div_valid` && `div_ready`. `div_ready`=1 in IDLE and RUN, and 0 in PEND.
  - In IDLE, the accepted value goes straight to `div_reg`.
  - In RUN, if the accept coincides with a wrap cycle, the new value goes straight to `div_reg` and the state stays RUN.
- Counting:
  - `cnt` increments each enabled cycle.
  - A wrap is the cycle with `cnt`==`div_reg`-1. On a wrap, `cnt`<=0 and `tick`<=1 on the next edge; otherwise `tick`<=0.
  - With `div_reg`=1, `tick` stays high continuously while enabled.
- Divisor rules:
  - A `div_data` value of 0 is stored as 1.
  - Values are unsigned.
  - The divisor in use never changes mid-period while enabled.
- `tick_count` increments on every edge where `tick` is driven 1. It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values: `tick`=0, `tick_count`=0, `div_ready`=1, `cnt`=0, `div_reg`=DEFAULT_DIV, state IDLE.
- Reset asserted mid-period: all state returns to the reset values immediately, and any pending divisor is discarded.
- Tick timing:
  - Edge k is the first edge that samples `en`=1. The first `tick` is high in the cycle after edge k+`div_reg`-1.
  - Later ticks are exactly `div_reg` clocks apart.
- `en` dropping on a wrap cycle: the `tick` for that wrap is still issued, then the block enters IDLE.
- New divisor latency: it takes effect for the period starting immediately after the current wrap, never splitting a period.
- Output register: `tick` is a flop output with no combinational path from any input.

## Structure
- Package `tick_pkg` holds:
  - the state enum {IDLE, RUN, PEND};
  - `SYS_CLK_HZ`=50_000_000;
  - `DEFAULT_DIV`;
  - `SIM_DIV`=20.
- Single module, no sub-modules. The counter, load FSM and tick-count register are kept together.

## Test plan
- Reset, then `en`=1 with DEFAULT_DIV=20: first `tick` 20 clocks after enable, then every 20 clocks. Each `tick` is exactly 1 cycle wide, and `tick_count` reads 1,2,3…
- In RUN, load 5 at `cnt`=7 of a 20-cycle period: `div_ready` drops for the rest of the period. The current period still ends at 20 clocks; the next periods are 5 clocks, and `div_ready` returns to 1 after the wrap.
- Load 0 while IDLE, then enable: `tick` is high every cycle, and `tick_count` increments every cycle, wrapping 255→0.
- Drop `en` at `cnt`=10: `tick` stays 0, and the counter clears. On re-enable, the first `tick` arrives after a full 20 clocks.
- Assert `rst_n`=0 while PEND, between clock edges: outputs go to the reset values immediately. After release, the period is 20 and the pending value is lost.
- Offer a load on the wrap cycle itself: it is accepted (`div_ready`=1) and applies to the very next period, and the FSM stays in RUN.
